sccb_target: RTL and testbench
==============================

# sccb_target

SCCB (I2C-compatible) target that emulates the camera end of the bus the OV7670 configuration sequencer drives. It oversamples the SIOC/SIOD lines in the system clock domain and decodes 3-phase writes, 2-phase sub-address writes and 2-phase reads. Write data goes into an internal 256×8 register file, with a write strobe exported for observers. It sits in the simulation and loopback path in place of the sensor, so the configuration sequencer and the SCCB master can be exercised end to end.

## Interface
Parameters:
- DEVICE_ID, 8'h42: write address of this target. The read address is DEVICE_ID | 1, and only bits [7:1] are compared.
- SYNC_STAGES, 2: synchronizer depth on SIOC and SIOD (minimum 2).

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  asynchronous, active-high reset.
- sioc  in  1  SCCB clock from the master.
- siod_in  in  1  SCCB data line as sensed.
- siod_oe  out  1  1 = pull SIOD low (open-drain); 0 = release.
- busy  out  1  high from a detected START until a detected STOP.
- reg_wr_en  out  1  one-cycle pulse per completed register write.
- reg_wr_addr  out  8  sub-address of the completed write.
- reg_wr_data  out  8  data of the completed write.

## Operation
- **Synchronization:** SIOC and SIOD pass through SYNC_STAGES flops. A further register provides edge detection: sioc_rise, sioc_fall, siod_rise, siod_fall.
- **START:** siod_fall while synced SIOC = 1 and no SIOC edge in the same cycle. STOP is siod_rise under the same condition. When a SIOC edge and a SIOD edge coincide, the SIOC edge wins and the event is treated as a data bit.
- **Bit sampling and driving:** bits are sampled on sioc_rise, MSB first. siod_oe changes only on sioc_fall.
- **State machine:** IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NACK, WAIT_STOP.
- **START from any state:** goes to ID, clears the bit counter and sets busy. This covers repeated START.
- **STOP from any state:** goes to IDLE, releases siod_oe and clears busy.
- **ID:** after 8 bits, if ID[7:1] != DEVICE_ID[7:1], go to WAIT_STOP with no ACK. Otherwise go to ID_ACK.
- **ACK generation:** on the sioc_fall after the 8th bit, siod_oe = 1. It is held through the 9th sioc_rise and released on the next sioc_fall.
- **After ID_ACK:** write (ID[0] = 0) goes to SUB; read goes to RDATA.
- **SUB:** the 8-bit byte loads the sub-address pointer. SUB_ACK follows, then WDATA.
- **WDATA:** on the 8th sioc_rise, regfile[pointer] <= byte, reg_wr_addr <= pointer, reg_wr_data <= byte, and reg_wr_en = 1 for exactly the next clk cycle. WDATA_ACK follows, then WAIT_STOP. Further bytes are not ACKed and produce no write.
- **2-phase write:** START, ID, SUB, then STOP. This updates only the pointer; no reg_wr_en.
- **RDATA:**
  - The byte regfile[pointer] is latched at ID_ACK completion.
  - On each sioc_fall, siod_oe = ~bit, MSB first, for 8 bits.
  - On the sioc_fall after bit 8, siod_oe = 0 and the state goes to RD_NACK.
  - The master's bit is sampled and ignored; then WAIT_STOP.
  - The pointer does not auto-increment.
- **WAIT_STOP:** siod_oe = 0, and all bits are ignored until START or STOP.
- **Reset:** the register file and the pointer reset to 0x00.

## Timing
- **Reset values:** siod_oe = 0, busy = 0, reg_wr_en = 0, reg_wr_addr = 0x00, reg_wr_data = 0x00, state IDLE.
- **Reset mid-transaction:** siod_oe drops asynchronously, with no clk edge needed. After reset the block ignores the bus until the next START.
- **Latency:** a line change becomes visible SYNC_STAGES + 1 clk cycles later.
- **Line changes:** siod_oe updates on the clk edge that registers sioc_fall, so SIOD changes during SIOC low.
- **Clock constraint:** SIOC high and low phases must each be ≥ SYNC_STAGES + 3 clk cycles. At 25 MHz clk and 100 kHz SCCB the margin is large.
- **Write strobe:** reg_wr_en is high exactly one clk cycle per write and never during reads. The register file is updated on the same edge that raises reg_wr_en.
- **busy:** rises one cycle after START is registered and falls one cycle after STOP is registered.

## Test plan
- **3-phase write:** START, 0x42, 0x12, 0x80, STOP → siod_oe = 1 during the 9th SIOC pulse of all three bytes; one reg_wr_en pulse with addr 0x12 and data 0x80; busy returns to 0 after STOP.
- **2-phase read:**
  - Write 0x42/0x0A/0x76, then 0x42/0x0A with STOP.
  - Then START, 0x43.
  - → ACK, SIOD reads back 0x76 MSB first, siod_oe = 0 during the NACK bit, no reg_wr_en.
- **Wrong ID:** START, 0x60, 0x12, 0x55, STOP → siod_oe never asserts, no reg_wr_en, busy is 1 only between START and STOP.
- **Repeated START:** START, 0x42, 0x12, then Sr, 0x43 → read returns regfile[0x12].
- **Extra byte:** START, 0x42, 0x12, 0x55, 0xAA, STOP → 0xAA is not ACKed; exactly one reg_wr_en; regfile[0x12] = 0x55.
- **Reset during read:**
  - Assert rst while siod_oe = 1 → siod_oe = 0 before the next clk edge.
  - After release, reading 0x12 returns 0x00.
  - A subsequent 3-phase write succeeds.

Source files
------------

// File: rtl/sccb_target.sv
// SCCB (I2C-compatible) camera-side target: oversamples SIOC/SIOD in the clk domain,
// decodes 3-phase writes, 2-phase sub-address writes and 2-phase reads against a 256x8 register file.
module sccb_target #(
    parameter logic [7:0] DEVICE_ID   = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sioc,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       busy,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data
);

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ID_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RD_NACK,
        WAIT_STOP
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sioc_sync, siod_sync;
    logic sioc_s, siod_s, sioc_d, siod_d;
    logic sioc_rise, sioc_fall, siod_rise, siod_fall;
    logic start_det, stop_det;

    logic [3:0] bit_cnt, bit_cnt_next;
    logic [6:0] shift, shift_next;
    logic [7:0] rx_byte;
    logic       is_read, is_read_next;
    logic [7:0] pointer, pointer_next;
    logic [7:0] rd_shift, rd_shift_next;
    logic       oe_next, busy_next, wr_fire;
    logic [7:0] regfile [256];
    logic [7:0] rd_byte;

    // Synchronizers reset to the idle-high bus level so reset release creates no edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sioc_sync <= '1;
            siod_sync <= '1;
            sioc_d    <= 1'b1;
            siod_d    <= 1'b1;
        end else begin
            sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
            siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod_in};
            sioc_d    <= sioc_s;
            siod_d    <= siod_s;
        end
    end

    assign sioc_s    = sioc_sync[SYNC_STAGES-1];
    assign siod_s    = siod_sync[SYNC_STAGES-1];
    assign sioc_rise = sioc_s & ~sioc_d;
    assign sioc_fall = ~sioc_s & sioc_d;
    assign siod_rise = siod_s & ~siod_d;
    assign siod_fall = ~siod_s & siod_d;

    // A coincident SIOC edge turns a SIOD edge into an ordinary data bit
    assign start_det = siod_fall & sioc_s & ~sioc_rise & ~sioc_fall;
    assign stop_det  = siod_rise & sioc_s & ~sioc_rise & ~sioc_fall;

    assign rx_byte = {shift, siod_s};
    assign rd_byte = regfile[pointer];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 7'd0;
            is_read  <= 1'b0;
            pointer  <= 8'h00;
            rd_shift <= 8'h00;
            siod_oe  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            shift    <= shift_next;
            is_read  <= is_read_next;
            pointer  <= pointer_next;
            rd_shift <= rd_shift_next;
            siod_oe  <= oe_next;
            busy     <= busy_next;
        end
    end

    // ACK states use siod_oe itself as the phase flag: first fall pulls low, second fall releases
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        is_read_next  = is_read;
        pointer_next  = pointer;
        rd_shift_next = rd_shift;
        oe_next       = siod_oe;
        busy_next     = busy;
        wr_fire       = 1'b0;

        if (start_det) begin
            state_next   = ID;
            bit_cnt_next = 4'd0;
            busy_next    = 1'b1;
            oe_next      = 1'b0;
        end else if (stop_det) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            oe_next    = 1'b0;
        end else begin
            case (state)
                ID, SUB, WDATA: begin
                    if (sioc_rise) begin
                        shift_next   = {shift[5:0], siod_s};
                        bit_cnt_next = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_next = 4'd0;
                            if (state == ID) begin
                                if (rx_byte[7:1] == DEVICE_ID[7:1]) begin
                                    state_next   = ID_ACK;
                                    is_read_next = rx_byte[0];
                                end else begin
                                    state_next = WAIT_STOP;
                                end
                            end else if (state == SUB) begin
                                pointer_next = rx_byte;
                                state_next   = SUB_ACK;
                            end else begin
                                wr_fire    = 1'b1;
                                state_next = WDATA_ACK;
                            end
                        end
                    end
                end
                ID_ACK, SUB_ACK, WDATA_ACK: begin
                    if (sioc_fall) begin
                        if (!siod_oe) begin
                            oe_next = 1'b1;
                        end else begin
                            oe_next      = 1'b0;
                            bit_cnt_next = 4'd0;
                            if (state == ID_ACK) begin
                                if (is_read) begin
                                    state_next    = RDATA;
                                    oe_next       = ~rd_byte[7];
                                    rd_shift_next = {rd_byte[6:0], 1'b0};
                                end else begin
                                    state_next = SUB;
                                end
                            end else if (state == SUB_ACK) begin
                                state_next = WDATA;
                            end else begin
                                state_next = WAIT_STOP;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (sioc_rise) begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end else if (sioc_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_next    = 1'b0;
                            state_next = RD_NACK;
                        end else begin
                            oe_next       = ~rd_shift[7];
                            rd_shift_next = {rd_shift[6:0], 1'b0};
                        end
                    end
                end
                RD_NACK: begin
                    if (sioc_rise) begin
                        state_next = WAIT_STOP;
                    end
                end
                WAIT_STOP: begin
                    oe_next = 1'b0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Register file and strobe share the edge that samples the 8th data bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                regfile[i] <= 8'h00;
            end
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 8'h00;
            reg_wr_data <= 8'h00;
        end else begin
            reg_wr_en <= wr_fire;
            if (wr_fire) begin
                regfile[pointer] <= rx_byte;
                reg_wr_addr      <= pointer;
                reg_wr_data      <= rx_byte;
            end
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: a bit-banged SCCB master over a wired-AND SIOD line,
// with write-strobe and siod_oe monitors sampled on the falling clk edge.
module tb_sccb_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sioc = 1'b1;
    logic       siod_m = 1'b1;
    logic       siod_line;
    logic       siod_oe, busy, reg_wr_en;
    logic [7:0] reg_wr_addr, reg_wr_data;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int oe_cycles = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_data = 8'h00;

    assign siod_line = siod_m & ~siod_oe;

    always #5 clk = ~clk;

    sccb_target #(.DEVICE_ID(8'h42), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .sioc(sioc),
        .siod_in(siod_line),
        .siod_oe(siod_oe),
        .busy(busy),
        .reg_wr_en(reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data)
    );

    // A strobe held longer than one cycle shows up as an extra count
    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) begin
            wr_cnt++;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
        if (siod_oe === 1'b1) oe_cycles++;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        siod_m = 1'b1; wait_q();
        sioc = 1'b1;   wait_q();
        siod_m = 1'b0; wait_q();
        sioc = 1'b0;   wait_q();
    endtask

    task automatic bus_stop();
        siod_m = 1'b0; wait_q();
        sioc = 1'b1;   wait_q();
        siod_m = 1'b1; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            siod_m = b[i]; wait_q();
            sioc = 1'b1;   wait_q(); wait_q();
            sioc = 1'b0;   wait_q();
        end
        siod_m = 1'b1; wait_q();
        sioc = 1'b1;   wait_q();
        ack = siod_oe; wait_q();
        sioc = 1'b0;   wait_q();
    endtask

    task automatic read_byte(output logic [7:0] d, output logic oe_nack);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            siod_m = 1'b1; wait_q();
            sioc = 1'b1;   wait_q();
            d = {d[6:0], siod_line}; wait_q();
            sioc = 1'b0;   wait_q();
        end
        siod_m = 1'b1;     wait_q();
        sioc = 1'b1;       wait_q();
        oe_nack = siod_oe; wait_q();
        sioc = 1'b0;       wait_q();
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        n_cmp++; if (siod_oe !== 1'b0) begin n_err++; $display("[TB] FAIL reset_oe: got %b expected 0", siod_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (reg_wr_en !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wr_en: got %b expected 0", reg_wr_en); end
        n_cmp++; if (reg_wr_addr !== 8'h00) begin n_err++; $display("[TB] FAIL reset_addr: got %h expected 00", reg_wr_addr); end
        n_cmp++; if (reg_wr_data !== 8'h00) begin n_err++; $display("[TB] FAIL reset_data: got %h expected 00", reg_wr_data); end
        rst = 1'b0;
        wait_q();
    endtask

    task automatic test_write3();
        logic a0, a1, a2;
        int w0;
        w0 = wr_cnt;
        bus_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL w3_busy_start: got %b expected 1", busy); end
        send_byte(8'h42, a0);
        send_byte(8'h12, a1);
        send_byte(8'h80, a2);
        bus_stop();
        wait_q();
        n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("[TB] FAIL w3_acks: got %b expected 111", {a0, a1, a2}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL w3_busy_stop: got %b expected 0", busy); end
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_err++; $display("[TB] FAIL w3_wr_count: got %0d expected 1", wr_cnt - w0); end
        n_cmp++; if (last_addr !== 8'h12) begin n_err++; $display("[TB] FAIL w3_addr: got %h expected 12", last_addr); end
        n_cmp++; if (last_data !== 8'h80) begin n_err++; $display("[TB] FAIL w3_data: got %h expected 80", last_data); end
    endtask

    task automatic test_read2();
        logic a0, a1, a2, nk;
        logic [7:0] d;
        int w0;
        bus_start(); send_byte(8'h42, a0); send_byte(8'h0A, a1); send_byte(8'h76, a2); bus_stop();
        n_cmp++; if (last_data !== 8'h76) begin n_err++; $display("[TB] FAIL rd_setup_data: got %h expected 76", last_data); end
        w0 = wr_cnt;
        bus_start(); send_byte(8'h42, a0); send_byte(8'h0A, a1); bus_stop();
        n_cmp++; if ({a0, a1} !== 2'b11) begin n_err++; $display("[TB] FAIL rd_2phase_acks: got %b expected 11", {a0, a1}); end
        bus_start(); send_byte(8'h43, a0); read_byte(d, nk); bus_stop();
        n_cmp++; if (a0 !== 1'b1) begin n_err++; $display("[TB] FAIL rd_id_ack: got %b expected 1", a0); end
        n_cmp++; if (d !== 8'h76) begin n_err++; $display("[TB] FAIL rd_data: got %h expected 76", d); end
        n_cmp++; if (nk !== 1'b0) begin n_err++; $display("[TB] FAIL rd_nack_oe: got %b expected 0", nk); end
        n_cmp++; if (wr_cnt !== w0) begin n_err++; $display("[TB] FAIL rd_no_write: got %0d expected %0d", wr_cnt, w0); end
    endtask

    task automatic test_wrong_id();
        logic a0, a1, a2;
        int w0, o0;
        w0 = wr_cnt;
        o0 = oe_cycles;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL wid_busy_before: got %b expected 0", busy); end
        bus_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL wid_busy_start: got %b expected 1", busy); end
        send_byte(8'h60, a0); send_byte(8'h12, a1); send_byte(8'h55, a2);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL wid_busy_mid: got %b expected 1", busy); end
        bus_stop();
        wait_q();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL wid_busy_stop: got %b expected 0", busy); end
        n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("[TB] FAIL wid_acks: got %b expected 000", {a0, a1, a2}); end
        n_cmp++; if (oe_cycles !== o0) begin n_err++; $display("[TB] FAIL wid_oe_cycles: got %0d expected %0d", oe_cycles, o0); end
        n_cmp++; if (wr_cnt !== w0) begin n_err++; $display("[TB] FAIL wid_no_write: got %0d expected %0d", wr_cnt, w0); end
    endtask

    task automatic test_repeated_start();
        logic a0, a1, a2, nk;
        logic [7:0] d;
        bus_start(); send_byte(8'h42, a0); send_byte(8'h12, a1);
        bus_start(); send_byte(8'h43, a2); read_byte(d, nk); bus_stop();
        n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("[TB] FAIL sr_acks: got %b expected 111", {a0, a1, a2}); end
        n_cmp++; if (d !== 8'h80) begin n_err++; $display("[TB] FAIL sr_data: got %h expected 80", d); end
    endtask

    task automatic test_extra_byte();
        logic a0, a1, a2, a3, nk;
        logic [7:0] d;
        int w0;
        w0 = wr_cnt;
        bus_start(); send_byte(8'h42, a0); send_byte(8'h12, a1); send_byte(8'h55, a2); send_byte(8'hAA, a3); bus_stop();
        n_cmp++; if ({a0, a1, a2, a3} !== 4'b1110) begin n_err++; $display("[TB] FAIL xb_acks: got %b expected 1110", {a0, a1, a2, a3}); end
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_err++; $display("[TB] FAIL xb_wr_count: got %0d expected 1", wr_cnt - w0); end
        n_cmp++; if (last_data !== 8'h55) begin n_err++; $display("[TB] FAIL xb_data: got %h expected 55", last_data); end
        bus_start(); send_byte(8'h42, a0); send_byte(8'h12, a1); bus_stop();
        bus_start(); send_byte(8'h43, a0); read_byte(d, nk); bus_stop();
        n_cmp++; if (d !== 8'h55) begin n_err++; $display("[TB] FAIL xb_readback: got %h expected 55", d); end
    endtask

    task automatic test_reset_during_read();
        logic a0, a1, a2, nk;
        logic [7:0] d;
        int w0;
        // regfile[0x12] holds 0x55, so the first read bit (0) keeps SIOD pulled low
        bus_start(); send_byte(8'h43, a0);
        siod_m = 1'b1; wait_q();
        sioc = 1'b1;   wait_q();
        n_cmp++; if (siod_oe !== 1'b1) begin n_err++; $display("[TB] FAIL rr_oe_before: got %b expected 1", siod_oe); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (siod_oe !== 1'b0) begin n_err++; $display("[TB] FAIL rr_oe_async: got %b expected 0", siod_oe); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_q();
        sioc = 1'b0; wait_q();
        bus_stop();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rr_busy_after: got %b expected 0", busy); end
        bus_start(); send_byte(8'h42, a0); send_byte(8'h12, a1);
        bus_start(); send_byte(8'h43, a2); read_byte(d, nk); bus_stop();
        n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("[TB] FAIL rr_read_acks: got %b expected 111", {a0, a1, a2}); end
        n_cmp++; if (d !== 8'h00) begin n_err++; $display("[TB] FAIL rr_cleared: got %h expected 00", d); end
        w0 = wr_cnt;
        bus_start(); send_byte(8'h42, a0); send_byte(8'h12, a1); send_byte(8'hC3, a2); bus_stop();
        n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("[TB] FAIL rr_write_acks: got %b expected 111", {a0, a1, a2}); end
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_err++; $display("[TB] FAIL rr_wr_count: got %0d expected 1", wr_cnt - w0); end
        n_cmp++; if ({last_addr, last_data} !== 16'h12C3) begin n_err++; $display("[TB] FAIL rr_wr_addr_data: got %h expected 12c3", {last_addr, last_data}); end
    endtask

    initial begin
        test_reset();
        test_write3();
        test_read2();
        test_wrong_id();
        test_repeated_start();
        test_extra_byte();
        test_reset_during_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
